data_mem_mmio: RTL and testbench

Word-addressed data memory with memory-mapped peripherals (LEDs, switches, seven-segment driver register, interval timer with interrupt request). Sits in the MEM stage of the pipelined MIPS core: the stage presents an ALU-computed byte address plus read/write enables and receives read data in the same cycle. One clock domain; all state updates on the rising edge of `clk`.

---
 rtl/data_mem_mmio_if.sv | 26 ++
 rtl/data_mem_mmio.sv | 151 +++++++++++++++
 tb/tb_data_mem_mmio.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_mmio_if.sv
// data_mem_mmio_if: MEM-stage load/store bus between the pipeline and the
// data memory. The master drives address, enables and store data. The slave
// returns combinational load data.
interface data_mem_mmio_if;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output read_enable,
    output write_enable,
    output address,
    output writedata,
    input  readdata
  );

  modport slave (
    input  read_enable,
    input  write_enable,
    input  address,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: word-addressed data RAM for the MEM stage. It also holds
// memory-mapped LED, switch and seven-segment registers and an optional
// interval timer.
// Define DMEM_TIMER_EN to build the TH/TL/TCON timer and its irq output.
// Without that macro, the timer window reads as zero and irq is tied low.
module data_mem_mmio #(
  parameter int MEM_WORDS = 256
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_mmio_if.slave  bus,
  input  logic [7:0]      switch,
  output logic [7:0]      led,
  output logic [17:0]     tube,
  output logic            irq
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Word addresses (byte address >> 2) of the peripheral registers.
  localparam logic [31:0] TH_WORD   = 32'h1000_0000;
  localparam logic [31:0] TL_WORD   = 32'h1000_0001;
  localparam logic [31:0] TCON_WORD = 32'h1000_0002;
  localparam logic [31:0] LED_WORD  = 32'h1000_0003;
  localparam logic [31:0] SW_WORD   = 32'h1000_0004;
  localparam logic [31:0] TUBE_WORD = 32'h1000_0005;

  logic [31:0]   word_addr;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic [31:0]   mem_q [MEM_WORDS];

  logic [7:0]  led_d, led_q;
  logic [17:0] tube_d, tube_q;

  // Word address decode. Byte-offset bits drop out in the shift.
  // The full remaining width is compared, so RAM does not alias upward.
  always_comb begin
    word_addr = bus.address >> 2;
    ram_hit   = (word_addr < 32'(MEM_WORDS));
    ram_idx   = word_addr[AW-1:0];
  end

  // RAM store port. The contents have no reset and are undefined until written.
  always_ff @(posedge clk) begin
    if (bus.write_enable && ram_hit) begin
      mem_q[ram_idx] <= bus.writedata;
    end
  end

  // Next state of the LED and seven-segment registers on a CPU store.
  always_comb begin
    led_d  = led_q;
    tube_d = tube_q;
    if (bus.write_enable && word_addr == LED_WORD) begin
      led_d = bus.writedata[7:0];
    end
    if (bus.write_enable && word_addr == TUBE_WORD) begin
      tube_d = bus.writedata[17:0];
    end
  end

  // Output register state. The synchronous reset clears both registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q  <= '0;
      tube_q <= '0;
    end else begin
      led_q  <= led_d;
      tube_q <= tube_d;
    end
  end

  assign led  = led_q;
  assign tube = tube_q;

`ifdef DMEM_TIMER_EN
  logic [31:0] th_d, th_q;
  logic [31:0] tl_d, tl_q;
  logic [2:0]  tcon_d, tcon_q;
  logic        cpu_owns_timer;

  // Timer next state. A CPU write to TL or TCON pre-empts that cycle's
  // count or reload, so software always sees exactly the value it stored.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    cpu_owns_timer = bus.write_enable &&
                     (word_addr == TL_WORD || word_addr == TCON_WORD);
    if (tcon_q[0] && !cpu_owns_timer) begin
      if (tl_q != 32'hFFFF_FFFF) begin
        tl_d = tl_q + 32'd1;
      end else begin
        tl_d = th_q;
        if (tcon_q[1]) begin
          tcon_d[2] = 1'b1;
        end
      end
    end
    if (bus.write_enable && word_addr == TH_WORD) begin
      th_d = bus.writedata;
    end
    if (bus.write_enable && word_addr == TL_WORD) begin
      tl_d = bus.writedata;
    end
    if (bus.write_enable && word_addr == TCON_WORD) begin
      tcon_d = bus.writedata[2:0];
    end
  end

  // Timer registers. Reset wins over any store pending in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign irq = tcon_q[2];
`else
  assign irq = 1'b0;
`endif

  // Combinational load path. It shows register state from before any
  // same-cycle store. Unmapped addresses read zero.
  always_comb begin
    bus.readdata = '0;
    if (bus.read_enable) begin
      if (ram_hit) begin
        bus.readdata = mem_q[ram_idx];
      end else begin
        case (word_addr)
          LED_WORD:  bus.readdata = {24'b0, led_q};
          SW_WORD:   bus.readdata = {24'b0, switch};
          TUBE_WORD: bus.readdata = {14'b0, tube_q};
`ifdef DMEM_TIMER_EN
          TH_WORD:   bus.readdata = th_q;
          TL_WORD:   bus.readdata = tl_q;
          TCON_WORD: bus.readdata = {29'b0, tcon_q};
`endif
          default:   bus.readdata = '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed-vector bench for data_mem_mmio.
// Stimulus pushes hand-computed expectations into a scoreboard queue.
// A negedge monitor pops each entry and compares it with what the DUT is presenting.
module tb_data_mem_mmio;
  typedef enum int {K_RD, K_LED, K_TUBE, K_IRQ} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [17:0] tube;
  logic        irq;

  data_mem_mmio_if bus();

  data_mem_mmio #(.MEM_WORDS(256)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .switch (switch),
    .led    (led),
    .tube   (tube),
    .irq    (irq)
  );

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] act;
  int          compared   = 0;
  int          mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of bus inputs just after the rising edge.
  task automatic applyStimulus(input logic re, input logic we,
                               input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.read_enable  = re;
    bus.write_enable = we;
    bus.address      = addr;
    bus.writedata    = wd;
  endtask

  // Queue an expectation for the output observed later in this cycle.
  task automatic checkOutput(input kind_t k, input logic [31:0] e, input string n);
    exp_t x;
    x.kind = k;
    x.exp  = e;
    x.name = n;
    sb.push_back(x);
  endtask

  // Monitor: compare everything queued for this cycle at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.kind)
        K_RD:    act = bus.readdata;
        K_LED:   act = {24'b0, led};
        K_TUBE:  act = {14'b0, tube};
        default: act = {31'b0, irq};
      endcase
      compared++;
      if (act !== cur.exp) begin
        mismatched++;
        $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", cur.name, act, cur.exp);
      end
    end
  end

  initial begin
    reset            = 1'b1;
    switch           = 8'h5C;
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    bus.address      = '0;
    bus.writedata    = '0;

    // Reset state
    applyStimulus(0, 0, 32'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    checkOutput(K_LED, 32'h0, "reset_led");
    checkOutput(K_TUBE, 32'h0, "reset_tube");
    checkOutput(K_IRQ, 32'h0, "reset_irq");
    checkOutput(K_RD, 32'h0, "reset_rd_gated");

    // RAM round trip, gating, byte offset ignored
    applyStimulus(0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 32'h0000_0010, 32'h0);
    checkOutput(K_RD, 32'hDEAD_BEEF, "ram_rd");
    applyStimulus(0, 0, 32'h0000_0010, 32'h0);
    checkOutput(K_RD, 32'h0, "ram_rd_disabled");
    applyStimulus(1, 0, 32'h0000_0013, 32'h0);
    checkOutput(K_RD, 32'hDEAD_BEEF, "ram_rd_offset3");
    // A same-cycle store is not visible on the load path
    applyStimulus(1, 1, 32'h0000_0010, 32'h0BAD_F00D);
    checkOutput(K_RD, 32'hDEAD_BEEF, "ram_no_bypass");
    applyStimulus(1, 0, 32'h0000_0010, 32'h0);
    checkOutput(K_RD, 32'h0BAD_F00D, "ram_rd_new");
    // Top word, and the first address past RAM does not alias word 0
    applyStimulus(0, 1, 32'h0000_03FC, 32'hCAFE_0001);
    applyStimulus(0, 1, 32'h0000_0000, 32'h1111_1111);
    applyStimulus(0, 1, 32'h0000_0400, 32'h2222_2222);
    applyStimulus(1, 0, 32'h0000_03FC, 32'h0);
    checkOutput(K_RD, 32'hCAFE_0001, "ram_top_word");
    applyStimulus(1, 0, 32'h0000_0000, 32'h0);
    checkOutput(K_RD, 32'h1111_1111, "ram_no_alias");
    applyStimulus(1, 0, 32'h0000_0400, 32'h0);
    checkOutput(K_RD, 32'h0, "past_ram_reads0");

    // LED, tube, switch
    applyStimulus(0, 1, 32'h4000_000C, 32'h0000_01A5);
    applyStimulus(1, 1, 32'h4000_0014, 32'h0003_FFFF);
    checkOutput(K_LED, 32'h0000_00A5, "led_write");
    checkOutput(K_RD, 32'h0, "tube_rd_before_edge");
    applyStimulus(1, 0, 32'h4000_000C, 32'h0);
    checkOutput(K_RD, 32'h0000_00A5, "led_rd");
    checkOutput(K_TUBE, 32'h0003_FFFF, "tube_write");
    applyStimulus(1, 0, 32'h4000_0014, 32'h0);
    checkOutput(K_RD, 32'h0003_FFFF, "tube_rd");
    applyStimulus(1, 1, 32'h4000_0010, 32'hFFFF_FFFF);
    checkOutput(K_RD, 32'h0000_005C, "switch_rd");

    // Unmapped address
    applyStimulus(0, 1, 32'h5000_0000, 32'h1234_5678);
    applyStimulus(1, 0, 32'h5000_0000, 32'h0);
    checkOutput(K_RD, 32'h0, "unmapped_rd");

`ifdef DMEM_TIMER_EN
    // Timer reload with interrupt enabled
    applyStimulus(0, 1, 32'h4000_0000, 32'hFFFF_FFF0);
    applyStimulus(0, 1, 32'h4000_0004, 32'hFFFF_FFFE);
    applyStimulus(0, 1, 32'h4000_0008, 32'h0000_0003);
    applyStimulus(1, 0, 32'h4000_0004, 32'h0);
    checkOutput(K_RD, 32'hFFFF_FFFE, "tl_start");
    applyStimulus(1, 0, 32'h4000_0004, 32'h0);
    checkOutput(K_RD, 32'hFFFF_FFFF, "tl_max");
    checkOutput(K_IRQ, 32'h0, "irq_before_ovf");
    applyStimulus(1, 0, 32'h4000_0004, 32'h0);
    checkOutput(K_RD, 32'hFFFF_FFF0, "tl_reload");
    checkOutput(K_IRQ, 32'h1, "irq_on_ovf");
    applyStimulus(1, 0, 32'h4000_0008, 32'h0);
    checkOutput(K_RD, 32'h0000_0007, "tcon_status");
    applyStimulus(1, 0, 32'h4000_0000, 32'h0);
    checkOutput(K_RD, 32'hFFFF_FFF0, "th_rd");
    applyStimulus(0, 1, 32'h4000_0008, 32'h0000_0003);
    checkOutput(K_IRQ, 32'h1, "irq_sticky");
    applyStimulus(1, 0, 32'h4000_0008, 32'h0);
    checkOutput(K_IRQ, 32'h0, "irq_cleared");
    checkOutput(K_RD, 32'h0000_0003, "tcon_after_clear");

    // A CPU store to TL at overflow takes priority over the reload
    applyStimulus(0, 1, 32'h4000_0004, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 32'h4000_0004, 32'h0000_0100);
    applyStimulus(1, 0, 32'h4000_0004, 32'h0);
    checkOutput(K_RD, 32'h0000_0100, "tl_cpu_wins");
    checkOutput(K_IRQ, 32'h0, "irq_cpu_wins");
    applyStimulus(1, 0, 32'h4000_0004, 32'h0);
    checkOutput(K_RD, 32'h0000_0101, "tl_count_resumes");

    // Interrupt disabled: reload happens and irq stays low
    applyStimulus(0, 1, 32'h4000_0008, 32'h0000_0001);
    applyStimulus(0, 1, 32'h4000_0004, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 32'h4000_0004, 32'h0);
    checkOutput(K_RD, 32'hFFFF_FFFF, "tl_max_noie");
    applyStimulus(1, 0, 32'h4000_0004, 32'h0);
    checkOutput(K_RD, 32'hFFFF_FFF0, "tl_reload_noie");
    checkOutput(K_IRQ, 32'h0, "irq_noie");
    applyStimulus(1, 0, 32'h4000_0008, 32'h0);
    checkOutput(K_RD, 32'h0000_0001, "tcon_noie");
`else
    // Timer window is inert when the timer is not built
    applyStimulus(0, 1, 32'h4000_0004, 32'h0000_0005);
    applyStimulus(0, 1, 32'h4000_0008, 32'h0000_0003);
    applyStimulus(1, 0, 32'h4000_0004, 32'h0);
    checkOutput(K_RD, 32'h0, "tl_absent");
    applyStimulus(1, 0, 32'h4000_0008, 32'h0);
    checkOutput(K_RD, 32'h0, "tcon_absent");
    checkOutput(K_IRQ, 32'h0, "irq_absent");
`endif

    // Reset mid-operation with a store pending in the same cycle
    applyStimulus(0, 1, 32'h4000_000C, 32'h0000_00FF);
    applyStimulus(0, 1, 32'h4000_0004, 32'h0000_0055);
    checkOutput(K_LED, 32'h0000_00FF, "led_ff");
    reset = 1'b1;
    applyStimulus(1, 0, 32'h4000_0004, 32'h0);
    reset = 1'b0;
    checkOutput(K_LED, 32'h0, "rst_led");
    checkOutput(K_TUBE, 32'h0, "rst_tube");
    checkOutput(K_IRQ, 32'h0, "rst_irq");
    checkOutput(K_RD, 32'h0, "rst_tl");
    applyStimulus(1, 0, 32'h4000_0000, 32'h0);
    checkOutput(K_RD, 32'h0, "rst_th");
    applyStimulus(1, 0, 32'h4000_0008, 32'h0);
    checkOutput(K_RD, 32'h0, "rst_tcon");
    applyStimulus(1, 0, 32'h0000_0010, 32'h0);
    checkOutput(K_RD, 32'h0BAD_F00D, "ram_survives_reset");

    applyStimulus(0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
